mgc_in_fifo_wait_rx: RTL and testbench

//  Receive-side buffered input port: the input-direction counterpart of the buffered/FIFO output ports.
//  An external producer pushes words with a valid/ready handshake (vz/lz/z).
//  The synthesized design pops them with its own load/valid handshake (ld/vd/d).

---
 rtl/mgc_in_fifo_wait_rx.sv | 91 +++++++++
 tb/tb_mgc_in_fifo_wait_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mgc_in_fifo_wait_rx.sv
// Receive-side buffered input port: a producer pushes words (vz/lz/z) into a
// fifo_sz-deep FIFO that the design pops with its own load/valid handshake (ld/vd/d).
module mgc_in_fifo_wait_rx #(
  parameter int rscid   = 0,
  parameter int width   = 8,
  parameter int fifo_sz = 8,
  parameter int ph_log2 = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             vz,
  input  logic [width-1:0] z,
  output logic             lz,
  input  logic             ld,
  output logic             vd,
  output logic [width-1:0] d,
  output logic [ph_log2:0] size
);

  // A single-entry FIFO still needs one pointer bit to keep the logic uniform.
  localparam int PW = (ph_log2 > 0) ? ph_log2 : 1;
  localparam int CW = ph_log2 + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(fifo_sz - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(fifo_sz);

  if (fifo_sz < 1 || ph_log2 < $clog2(fifo_sz) || rscid < 0) begin : g_param_chk
    $error("mgc_in_fifo_wait_rx: illegal parameter combination");
  end

  logic [width-1:0] mem_q [fifo_sz];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push;
  logic             pop;

  // Wrap explicitly at fifo_sz-1 so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign lz   = ~srst & (count_q != FULL_CNT);
  assign vd   = ~srst & (count_q != {CW{1'b0}});
  assign d    = vd ? mem_q[rd_ptr_q] : {width{1'b0}};
  assign size = srst ? {CW{1'b0}} : count_q;
  assign push = vz & lz;
  assign pop  = ld & vd;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; push is already blocked while srst is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= z;
    end
  end

endmodule

// File: tb/tb_mgc_in_fifo_wait_rx.sv
// Bench for mgc_in_fifo_wait_rx: depth-8 and depth-5 instances checked every cycle
// against queue-based reference models, plus directed latency/full/wrap/reset scenarios.
module tb_mgc_in_fifo_wait_rx;

  localparam int DEP [2] = '{8, 5};

  logic       clk = 1'b0;
  logic       srst_a [2];
  logic       vz_a   [2];
  logic [7:0] z_a    [2];
  logic       ld_a   [2];
  logic       lz_a   [2];
  logic       vd_a   [2];
  logic [7:0] d_a    [2];
  logic [3:0] sz_a   [2];
  logic       hold   [2];

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mgc_in_fifo_wait_rx #(.rscid(1), .width(8), .fifo_sz(8), .ph_log2(3)) dut8 (
    .clk(clk), .srst(srst_a[0]), .vz(vz_a[0]), .z(z_a[0]), .lz(lz_a[0]),
    .ld(ld_a[0]), .vd(vd_a[0]), .d(d_a[0]), .size(sz_a[0]));

  mgc_in_fifo_wait_rx #(.rscid(2), .width(8), .fifo_sz(5), .ph_log2(3)) dut5 (
    .clk(clk), .srst(srst_a[1]), .vz(vz_a[1]), .z(z_a[1]), .lz(lz_a[1]),
    .ld(ld_a[1]), .vd(vd_a[1]), .d(d_a[1]), .size(sz_a[1]));

  // Producer must hold vz/z while stalled by a full FIFO.
  a_hold8: assert property (@(posedge clk)
    (vz_a[0] && !lz_a[0] && !srst_a[0]) |=> (vz_a[0] && $stable(z_a[0])))
    else $error("producer hold violated on depth-8 port");
  a_hold5: assert property (@(posedge clk)
    (vz_a[1] && !lz_a[1] && !srst_a[1]) |=> (vz_a[1] && $stable(z_a[1])))
    else $error("producer hold violated on depth-5 port");

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int msize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] mhead(input int k);
    if (k == 0) return (q0.size() != 0) ? q0[0] : 8'h00;
    return (q1.size() != 0) ? q1[0] : 8'h00;
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int   n    = msize(k);
      logic e_lz = !srst_a[k] && (n != DEP[k]);
      logic e_vd = !srst_a[k] && (n != 0);
      check_eq($sformatf("lz_d%0d", DEP[k]), lz_a[k], e_lz);
      check_eq($sformatf("vd_d%0d", DEP[k]), vd_a[k], e_vd);
      check_eq($sformatf("d_d%0d", DEP[k]), d_a[k], e_vd ? mhead(k) : 8'h00);
      check_eq($sformatf("size_d%0d", DEP[k]), sz_a[k], srst_a[k] ? 0 : n);
    end
  endtask

  task automatic update_models();
    for (int k = 0; k < 2; k++) begin
      int   n    = msize(k);
      logic full = (n == DEP[k]);
      logic p    = ld_a[k] && (n != 0);
      logic u    = vz_a[k] && !full;
      hold[k] = vz_a[k] && !srst_a[k] && full;
      if (srst_a[k]) begin
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        if (k == 0) begin
          if (p) void'(q0.pop_front());
          if (u) q0.push_back(z_a[k]);
        end else begin
          if (p) void'(q1.pop_front());
          if (u) q1.push_back(z_a[k]);
        end
      end
    end
  endtask

  // Inputs are set after a posedge, checked at the negedge, consumed at the next posedge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    update_models();
    #1;
  endtask

  initial begin
    int acc;
    int pcnt;
    for (int k = 0; k < 2; k++) begin
      srst_a[k] = 1'b1; vz_a[k] = 1'b0; z_a[k] = 8'h00; ld_a[k] = 1'b0; hold[k] = 1'b0;
    end
    step();

    // Reset with vz and ld active.
    for (int k = 0; k < 2; k++) begin vz_a[k] = 1'b1; ld_a[k] = 1'b1; z_a[k] = 8'hFF; end
    step();
    step();
    check_eq("rst_lz", lz_a[0], 0);
    check_eq("rst_vd", vd_a[0], 0);
    check_eq("rst_d", d_a[0], 8'h00);
    check_eq("rst_size", sz_a[0], 0);
    for (int k = 0; k < 2; k++) begin srst_a[k] = 1'b0; vz_a[k] = 1'b0; ld_a[k] = 1'b0; end
    #1;
    check_eq("rel_lz", lz_a[0], 1);
    step();

    // Write-to-read latency.
    vz_a[0] = 1'b1; z_a[0] = 8'hA5;
    step();
    vz_a[0] = 1'b0;
    check_eq("lat_vd", vd_a[0], 1);
    check_eq("lat_d", d_a[0], 8'hA5);
    check_eq("lat_size", sz_a[0], 1);
    ld_a[0] = 1'b1;
    step();
    ld_a[0] = 1'b0;
    check_eq("lat_pop_vd", vd_a[0], 0);
    check_eq("lat_pop_size", sz_a[0], 0);

    // Fill to full, then a stalled push during a pop.
    for (int i = 1; i <= 8; i++) begin vz_a[0] = 1'b1; z_a[0] = 8'(i); step(); end
    check_eq("full_size", sz_a[0], 8);
    check_eq("full_lz", lz_a[0], 0);
    z_a[0] = 8'h09; ld_a[0] = 1'b1;
    check_eq("full_head", d_a[0], 8'h01);
    step();
    ld_a[0] = 1'b0;
    check_eq("stall_size", sz_a[0], 7);
    step();
    vz_a[0] = 1'b0;
    check_eq("stall_accept_size", sz_a[0], 8);
    for (int i = 2; i <= 9; i++) begin
      ld_a[0] = 1'b1;
      check_eq("full_order", d_a[0], 8'(i));
      step();
    end
    ld_a[0] = 1'b0;
    check_eq("drain_vd", vd_a[0], 0);

    // Simultaneous push/pop at count=3 across pointer wrap.
    for (int i = 0; i < 3; i++) begin vz_a[0] = 1'b1; z_a[0] = 8'(8'h10 + i); step(); end
    for (int i = 0; i < 20; i++) begin
      vz_a[0] = 1'b1; z_a[0] = 8'(8'h13 + i); ld_a[0] = 1'b1;
      check_eq("pp_size", sz_a[0], 3);
      check_eq("pp_order", d_a[0], 8'(8'h10 + i));
      step();
    end
    vz_a[0] = 1'b0;
    for (int i = 20; i < 23; i++) begin
      check_eq("pp_drain", d_a[0], 8'(8'h10 + i));
      step();
    end
    ld_a[0] = 1'b0;

    // Mid-operation reset.
    for (int i = 0; i < 4; i++) begin vz_a[0] = 1'b1; z_a[0] = 8'(8'h50 + i); step(); end
    vz_a[0] = 1'b0;
    check_eq("mr_size4", sz_a[0], 4);
    srst_a[0] = 1'b1;
    step();
    check_eq("mr_size", sz_a[0], 0);
    check_eq("mr_vd", vd_a[0], 0);
    srst_a[0] = 1'b0; vz_a[0] = 1'b1; z_a[0] = 8'h3C;
    step();
    vz_a[0] = 1'b0;
    check_eq("mr_d", d_a[0], 8'h3C);
    check_eq("mr_size1", sz_a[0], 1);
    ld_a[0] = 1'b1;
    step();
    ld_a[0] = 1'b0;
    check_eq("mr_empty", vd_a[0], 0);

    // Depth 5: 12 words through random push/pop so pointers wrap 4->0.
    acc = 0;
    pcnt = 0;
    for (int c = 0; c < 300 && (acc < 12 || msize(1) != 0); c++) begin
      if (!hold[1]) begin
        vz_a[1] = (acc < 12) && ($urandom_range(0, 3) != 0);
        z_a[1]  = 8'(8'h80 + acc);
      end
      ld_a[1] = 1'($urandom_range(0, 1));
      if (ld_a[1] && msize(1) != 0) begin
        check_eq("wrap5_order", d_a[1], 8'(8'h80 + pcnt));
        pcnt++;
      end
      if (vz_a[1] && msize(1) != 5) acc++;
      check_eq("wrap5_size_le5", 32'(sz_a[1] <= 4'd5), 1);
      step();
    end
    vz_a[1] = 1'b0; ld_a[1] = 1'b0;
    check_eq("wrap5_count", pcnt, 12);

    // Random traffic on both ports with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        srst_a[k] = ($urandom_range(0, 49) == 0);
        if (!hold[k]) begin
          vz_a[k] = 1'($urandom_range(0, 1));
          z_a[k]  = 8'($urandom);
        end
        ld_a[k] = ($urandom_range(0, 2) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
